instr_mem_sync: RTL

Parametrised, synchronous instruction memory for the pipelined ARM-subset core. It replaces the combinational case-table ROM with a writable RAM. Features:
- Loader write port, fed by the testbench or boot loader.
- One-cycle registered fetch, with stall, flush and error reporting.
- Post-reset clear sweep.

Sits between IF-stage PC register and IF/ID pipeline register.

---
 rtl/instr_mem_pkg.sv | 21 ++
 rtl/instr_mem_array.sv | 48 ++++
 rtl/instr_mem_sync.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and address helpers for the synchronous instruction memory.
// Word index is byte address [idx_w+1:2]; anything misaligned or above the array is rejected.
package instr_mem_pkg;

  localparam int          INSTR_W_DEF  = 32;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  function automatic logic [31:0] addr_to_idx(input logic [31:0] addr, input int unsigned idx_w);
    return (addr >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned idx_w);
    return (addr[1:0] == 2'b00) && ((addr >> (idx_w + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Single-clock RAM, one write and one combinational read port, write-first on address match.
// INSTR_MEM_PARITY_EN adds a stored even-parity bit per word and a read-side mismatch flag.
module instr_mem_array #(
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [INSTR_W-1:0]       wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [INSTR_W-1:0]       rdata,
  output logic                     rd_par_err
);

`ifdef INSTR_MEM_PARITY_EN
  localparam int MEM_W = INSTR_W + 1;
`else
  localparam int MEM_W = INSTR_W;
`endif

  logic [MEM_W-1:0] mem_q [DEPTH];
  logic [MEM_W-1:0] wword;
  logic [MEM_W-1:0] rword;

`ifdef INSTR_MEM_PARITY_EN
  assign wword = {^wdata, wdata};
`else
  assign wword = wdata;
`endif

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wword;
    end
  end

  // A same-edge write wins over the stored word so a fetch never sees stale data.
  assign rword = (we && (waddr == raddr)) ? wword : mem_q[raddr];
  assign rdata = rword[INSTR_W-1:0];

`ifdef INSTR_MEM_PARITY_EN
  assign rd_par_err = ^rword;
`else
  assign rd_par_err = 1'b0;
`endif

endmodule

// File: rtl/instr_mem_sync.sv
// Writable instruction memory between the PC register and IF/ID: 1-cycle registered fetch, stall holds, flush squashes.
// After reset an optional sweep writes NOP_WORD everywhere (busy high); INSTR_MEM_PARITY_EN enables parity_err.
module instr_mem_sync
  import instr_mem_pkg::*;
#(
  parameter int                 INSTR_W        = INSTR_W_DEF,
  parameter int                 DEPTH          = 64,
  parameter logic [INSTR_W-1:0] NOP_WORD       = INSTR_W'(NOP_WORD_DEF),
  parameter bit                 CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_req,
  input  logic [31:0]        fetch_addr,
  input  logic               stall,
  input  logic               flush,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               fetch_err,
  output logic               busy,
  input  logic               wr_en,
  input  logic [31:0]        wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  output logic               parity_err
);

  localparam int               IDX_W     = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam state_e           RST_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic               fetch_err_q, fetch_err_d;
  logic               parity_err_q, parity_err_d;

  logic               rd_ok, wr_ok;
  logic [IDX_W-1:0]   rd_idx, wr_idx;
  logic               mem_we;
  logic [IDX_W-1:0]   mem_waddr;
  logic [INSTR_W-1:0] mem_wdata;
  logic [INSTR_W-1:0] rd_data;
  logic               rd_par_err;

  assign rd_ok  = addr_ok(fetch_addr, IDX_W);
  assign wr_ok  = addr_ok(wr_addr, IDX_W);
  assign rd_idx = IDX_W'(addr_to_idx(fetch_addr, IDX_W));
  assign wr_idx = IDX_W'(addr_to_idx(wr_addr, IDX_W));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Busy drops on the edge that writes the last index, so the sweep is exactly DEPTH cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = RST_STATE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = wr_idx;
    mem_wdata = wr_data;
    case (state_q)
      CLEAR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = NOP_WORD;
      end
      RUN:     mem_we = wr_en && wr_ok;
      default: busy = 1'b0;
    endcase
  end

  instr_mem_array #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) u_array (
    .clk        (clk),
    .we         (mem_we),
    .waddr      (mem_waddr),
    .wdata      (mem_wdata),
    .raddr      (rd_idx),
    .rdata      (rd_data),
    .rd_par_err (rd_par_err)
  );

  always_comb begin
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fetch_err_d   = fetch_err_q;
    parity_err_d  = parity_err_q;
    if (state_q == RUN) begin
      if (flush) begin
        instr_d       = NOP_WORD;
        instr_valid_d = 1'b0;
        fetch_err_d   = 1'b0;
        parity_err_d  = 1'b0;
      end else if (stall) begin
        parity_err_d  = 1'b0;
      end else if (fetch_req) begin
        instr_valid_d = 1'b1;
        if (rd_ok) begin
          instr_d      = rd_data;
          fetch_err_d  = 1'b0;
          parity_err_d = rd_par_err;
        end else begin
          instr_d      = NOP_WORD;
          fetch_err_d  = 1'b1;
          parity_err_d = 1'b0;
        end
      end else begin
        instr_valid_d = 1'b0;
        fetch_err_d   = 1'b0;
        parity_err_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q       <= NOP_WORD;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
    end else begin
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fetch_err_q   <= fetch_err_d;
      parity_err_q  <= parity_err_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign fetch_err   = fetch_err_q;
  assign parity_err  = parity_err_q;

endmodule
